data_store_pp: RTL and testbench
================================

// Module: data_store_pp
// PURPOSE
//  Parametrised ping-pong sample store for the channelised frequency-selector datapath.
//  Accepts a stream of (data, channel index) beats and writes them into a circular RAM of
//  2**ADDR_W words. The RAM is split into two halves. The block flags each half as it fills,
//  so the readout side can drain one half while the other keeps filling.
//  Adds arm/stop control, frame alignment on channel 0, ack handshake and sticky overflow.
// PARAMETERS
//  DATA_W  64  sample width in bits
//  IDX_W   7   channel index width (2**IDX_W channels)
//  ADDR_W  12  RAM address width; DEPTH = 2**ADDR_W, HALF = DEPTH/2
// PORTS
//  clk           in   1       single clock for the whole block
//  rst           in   1       synchronous reset, active-low
//  arm           in   1       1-cycle pulse: restart capture (enter SYNC)
//  stop          in   1       1-cycle pulse: end capture (enter IDLE)
//  data_in       in   DATA_W  sample data
//  index         in   IDX_W   channel index of data_in
//  valid         in   1       data_in/index qualify this cycle
//  ack           in   1       1-cycle pulse: reader has consumed the flagged half
//  rd_en         in   1       read request
//  rd_addr       in   ADDR_W  read address
//  data_out      out  DATA_W  read data
//  rd_valid      out  1       data_out valid (one cycle)
//  assert        out  1       a completed half is ready and not yet acked
//  assert_msb    out  1       which half is ready (0 = lower, 1 = upper)
//  assert_index  out  IDX_W   channel index of the last sample written into that half
//  overflow      out  1       sticky: a half completed while assert was still 1
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst == 0 at posedge):
//   - state = IDLE, wr_ptr = 0.
//   - assert, assert_msb, assert_index, overflow, rd_valid, data_out = 0.
//   - RAM contents are not cleared. Reset mid-capture aborts immediately.
//  FSM states:
//   - IDLE: valid ignored. arm -> SYNC.
//   - SYNC: on entry wr_ptr = 0, assert = 0, overflow = 0. The first beat with valid && index == 0
//     is written at address 0, wr_ptr = 1, -> RUN. Beats before it are dropped.
//   - RUN: each valid beat writes mem[wr_ptr] = data_in, then wr_ptr = wr_ptr + 1 mod DEPTH
//     (wraps DEPTH-1 -> 0).
//   - arm in SYNC or RUN -> SYNC (restart). stop in SYNC or RUN -> IDLE; wr_ptr is held.
//   - arm and stop in the same cycle: arm wins.
//  Half completion: a write to address HALF-1 or DEPTH-1. In the following cycle:
//   - assert = 1, assert_msb = MSB of the written address, assert_index = index of that beat.
//   - If assert was already 1 and no ack arrives that cycle: overflow = 1 (sticky).
//     assert_msb and assert_index still update to the newest half.
//  ack clears assert in the next cycle.
//   - ack coincident with a half completion: the new half wins (assert stays 1, fields update,
//     no overflow).
//   - ack while assert == 0 is ignored.
//   - overflow clears only on reset or SYNC entry.
//  Read: rd_en at cycle N -> data_out = mem[rd_addr] and rd_valid = 1 at cycle N+1.
//   - rd_valid = 0 otherwise; data_out holds its last value.
//   - Reads are allowed in any state.
//   - Read and write to the same address in the same cycle: read-first (returns old data).
//  Pipelining: throughput of 1 write and 1 read per cycle, with no backpressure.
// TESTING
//  1. arm, then 8196 beats data = n, index = n % 128 -> assert rises 1 cycle after beat 2047
//     (msb 0, assert_index 127) and after beat 4095 (msb 1); ack each flag within 10 cycles.
//     A full read afterwards returns addr 0..3 = 8192..8195 and addr 4..4095 = 4100..8191,
//     with overflow = 0.
//  2. arm, then a stream starting at index 5, data = 1000 + n -> the first stored word is the
//     index-0 beat (data 1123) at addr 0; the 123 earlier beats are dropped.
//  3. Stream 4096 aligned beats with no ack -> overflow = 1 one cycle after beat 4095,
//     assert_msb = 1; overflow stays 1 after a later ack.
//  4. ack in the same cycle as the write to addr 4095 with assert = 1 -> assert stays 1,
//     msb = 1, overflow = 0.
//  5. rd_en with rd_addr = 10 in the same cycle that mem[10] is overwritten -> data_out is the
//     old value with rd_valid = 1 at the next cycle; a read one cycle later returns the new value.
//  6. Drive rst = 0 mid-RUN for 1 cycle -> all outputs 0, busy = 0. Beats are ignored until
//     arm; after arm, capture restarts at addr 0.

Source files
------------

// File: rtl/data_store_pp.sv
// data_store_pp: ping-pong sample store with channel-0 frame alignment, per-half ready flags,
// ack handshake and sticky overflow; single-port-write / single-port-read circular RAM.
module data_store_pp #(
   parameter int DATA_W = 64,
   parameter int IDX_W  = 7,
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              arm_i,
   input  logic              stop_i,
   input  logic [DATA_W-1:0] data_in_i,
   input  logic [IDX_W-1:0]  index_i,
   input  logic              valid_i,
   input  logic              ack_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic              rd_valid_o,
   output logic              assert_o,
   output logic              assert_msb_o,
   output logic [IDX_W-1:0]  assert_index_o,
   output logic              overflow_o,
   output logic              busy_o
);
   typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              assert_q, assert_d, msb_q, msb_d, ovf_q, ovf_d, rd_valid_q;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_out_q;
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic              wr_en, half_done;
   // a beat coinciding with arm/stop is dropped; SYNC only accepts the channel-0 beat
   assign wr_en = rst_i && valid_i && !arm_i && !stop_i &&
                  (state_q == RUN || (state_q == SYNC && index_i == '0));
   assign half_done = wr_en && (&wr_ptr_q[ADDR_W-2:0]);
   always_comb begin
      state_d  = arm_i ? SYNC : (stop_i && state_q != IDLE) ? IDLE : wr_en ? RUN : state_q;
      wr_ptr_d = arm_i ? '0 : wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      assert_d = arm_i ? 1'b0 : half_done ? 1'b1 : ack_i ? 1'b0 : assert_q;
      msb_d    = half_done ? wr_ptr_q[ADDR_W-1] : msb_q;
      idx_d    = half_done ? index_i : idx_q;
      ovf_d    = arm_i ? 1'b0 : ovf_q | (half_done && assert_q && !ack_i);
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         assert_q <= 1'b0;
         msb_q    <= 1'b0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         assert_q <= assert_d;
         msb_q    <= msb_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
      end
   end
   // RAM array kept reset-free so it maps onto block memory
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_in_i;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_valid_q <= 1'b0;
         data_out_q <= '0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) data_out_q <= mem_q[rd_addr_i];
      end
   end
   assign data_out_o     = data_out_q;
   assign rd_valid_o     = rd_valid_q;
   assign assert_o       = assert_q;
   assign assert_msb_o   = msb_q;
   assign assert_index_o = idx_q;
   assign overflow_o     = ovf_q;
   assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_data_store_pp.sv
// tb_data_store_pp: directed scenarios plus a randomized run, checked against a behavioural model
module tb_data_store_pp;
   localparam int DW    = 64;
   localparam int IW    = 7;
   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;
   localparam int HALF  = DEPTH / 2;
   logic          clk = 1'b0;
   logic          rst = 1'b0, arm = 1'b0, stop = 1'b0, valid = 1'b0, ack = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] din = '0;
   logic [IW-1:0] idx = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid, asrt, asrt_msb, ovf, busy;
   logic [IW-1:0] asrt_idx;
   int n_checks = 0;
   int n_fail = 0;
   int            m_state = 0;
   int            m_ptr = 0;
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_assert = 1'b0, m_msb = 1'b0, m_ovf = 1'b0, m_rdv = 1'b0;
   logic [IW-1:0] m_idx = '0;
   logic [DW-1:0] m_dout = '0;
   always #5 clk = ~clk;
   data_store_pp #(.DATA_W(DW), .IDX_W(IW), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_i(rst), .arm_i(arm), .stop_i(stop), .data_in_i(din), .index_i(idx),
      .valid_i(valid), .ack_i(ack), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
      .data_out_o(data_out), .rd_valid_o(rd_valid), .assert_o(asrt), .assert_msb_o(asrt_msb),
      .assert_index_o(asrt_idx), .overflow_o(ovf), .busy_o(busy)
   );
   // model states: 0 idle, 1 waiting for channel 0, 2 capturing
   function automatic void model_step();
      bit take;
      m_rdv = rd_en;
      if (rd_en) m_dout = m_mem[rd_addr];
      if (!rst) begin
         m_state = 0; m_ptr = 0; m_assert = 0; m_msb = 0; m_idx = '0; m_ovf = 0;
         m_rdv = 0; m_dout = '0;
         return;
      end
      if (arm) begin
         m_state = 1; m_ptr = 0; m_assert = 0; m_ovf = 0;
         return;
      end
      if (stop && m_state != 0) begin
         m_state = 0;
         if (ack) m_assert = 0;
         return;
      end
      take = valid && (m_state == 2 || (m_state == 1 && idx == 0));
      if (take && (m_ptr % HALF) == HALF - 1) begin
         if (m_assert && !ack) m_ovf = 1;
         m_assert = 1;
         m_msb = (m_ptr >= HALF);
         m_idx = idx;
      end else if (ack) m_assert = 0;
      if (take) begin
         m_mem[m_ptr] = din;
         m_ptr = (m_ptr + 1) % DEPTH;
         m_state = 2;
      end
   endfunction
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      arm = 0; stop = 0; valid = 0; ack = 0; rd_en = 0;
   endtask
   task automatic test_reset();
      rst = 0; rd_en = 1;
      tick(); tick();
      n_checks++;
      if ({asrt, asrt_msb, asrt_idx, ovf, busy, rd_valid} !== '0)
         begin n_fail++; $display("FAIL reset_flags: got %b exp 0", {asrt, asrt_msb, asrt_idx, ovf, busy, rd_valid}); end
      n_checks++;
      if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", data_out); end
      rst = 1; valid = 1; idx = '0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_valid: busy %b exp 0", busy); end
   endtask
   task automatic test_fill();
      int n, dly, cyc, rises;
      bit v, exp_rise;
      n = 0; dly = -1; cyc = 0; rises = 0;
      arm = 1; tick();
      while ((n < 8196 || m_assert) && cyc < 20000) begin
         v = (n < 8196) && ($urandom_range(0, 3) != 0);
         valid = v; din = DW'(n); idx = IW'(n % 128); ack = (dly == 0);
         exp_rise = v && (n % HALF == HALF - 1);
         tick();
         cyc++;
         if (v) n++;
         dly = (dly == 0) ? -1 : (dly > 0) ? dly - 1 : (m_assert ? int'($urandom_range(0, 8)) : -1);
         n_checks++;
         if ({asrt, asrt_msb, asrt_idx, ovf, busy} !== {m_assert, m_msb, m_idx, m_ovf, m_state != 0})
            begin n_fail++; $display("FAIL fill_flags: got %b exp %b", {asrt, asrt_msb, asrt_idx, ovf, busy}, {m_assert, m_msb, m_idx, m_ovf, m_state != 0}); end
         if (exp_rise) begin
            n_checks++;
            if ({asrt, asrt_msb, asrt_idx} !== {1'b1, rises[0], 7'd127})
               begin n_fail++; $display("FAIL fill_half_rise: got %b exp %b", {asrt, asrt_msb, asrt_idx}, {1'b1, rises[0], 7'd127}); end
            rises++;
         end
      end
      n_checks++;
      if (cyc >= 20000) begin n_fail++; $display("FAIL fill_timeout: cycles %0d limit 20000", cyc); end
      n_checks++;
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b exp 0", ovf); end
      stop = 1; tick();
      for (int a = 0; a < DEPTH; a++) begin
         rd_en = 1; rd_addr = AW'(a);
         tick();
         n_checks++;
         if (data_out !== DW'(a < 4 ? 8192 + a : 4096 + a) || rd_valid !== 1'b1)
            begin n_fail++; $display("FAIL fill_read addr %0d: got %0d/%b exp %0d/1", a, data_out, rd_valid, a < 4 ? 8192 + a : 4096 + a); end
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || data_out !== DW'(8191))
         begin n_fail++; $display("FAIL read_hold: got %0d/%b exp 8191/0", data_out, rd_valid); end
   endtask
   task automatic test_align();
      arm = 1; tick();
      for (int k = 0; k < 200; k++) begin
         valid = 1; din = DW'(1000 + k); idx = IW'((5 + k) % 128);
         tick();
      end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL align_busy: got %b exp 1", busy); end
      stop = 1; tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b exp 0", busy); end
      rd_en = 1; rd_addr = 0; tick();
      n_checks++;
      if (data_out !== DW'(1123)) begin n_fail++; $display("FAIL align_addr0: got %0d exp 1123", data_out); end
      rd_en = 1; rd_addr = 1; tick();
      n_checks++;
      if (data_out !== DW'(1124)) begin n_fail++; $display("FAIL align_addr1: got %0d exp 1124", data_out); end
      rd_en = 1; rd_addr = 76; tick();
      n_checks++;
      if (data_out !== DW'(1199)) begin n_fail++; $display("FAIL align_addr76: got %0d exp 1199", data_out); end
   endtask
   task automatic test_overflow();
      arm = 1; tick();
      for (int n = 0; n < 4096; n++) begin
         valid = 1; din = {$urandom, $urandom}; idx = IW'(n % 128);
         tick();
         n_checks++;
         if ({asrt, asrt_msb, asrt_idx, ovf} !== {m_assert, m_msb, m_idx, m_ovf})
            begin n_fail++; $display("FAIL ovf_flags beat %0d: got %b exp %b", n, {asrt, asrt_msb, asrt_idx, ovf}, {m_assert, m_msb, m_idx, m_ovf}); end
         if (n == 2047) begin
            n_checks++;
            if ({asrt, asrt_msb, ovf} !== 3'b100) begin n_fail++; $display("FAIL ovf_first_half: got %b exp 100", {asrt, asrt_msb, ovf}); end
         end
      end
      n_checks++;
      if ({asrt, asrt_msb, asrt_idx, ovf} !== {1'b1, 1'b1, 7'd127, 1'b1})
         begin n_fail++; $display("FAIL ovf_second_half: got %b exp %b", {asrt, asrt_msb, asrt_idx, ovf}, {1'b1, 1'b1, 7'd127, 1'b1}); end
      ack = 1; tick();
      n_checks++;
      if ({asrt, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_after_ack: got %b exp 01", {asrt, ovf}); end
      tick();
      n_checks++;
      if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", ovf); end
   endtask
   task automatic test_ack_collide();
      arm = 1; tick();
      n_checks++;
      if ({asrt, ovf} !== 2'b00) begin n_fail++; $display("FAIL sync_clears: got %b exp 00", {asrt, ovf}); end
      for (int n = 0; n < 4096; n++) begin
         valid = 1; din = {$urandom, $urandom}; idx = IW'(n % 128); ack = (n == 4095);
         tick();
      end
      n_checks++;
      if ({asrt, asrt_msb, ovf} !== 3'b110) begin n_fail++; $display("FAIL ack_collide: got %b exp 110", {asrt, asrt_msb, ovf}); end
   endtask
   task automatic test_rw_collide();
      logic [DW-1:0] old_w, new_w;
      for (int n = 0; n < 10; n++) begin
         valid = 1; din = {$urandom, $urandom}; idx = IW'(n);
         tick();
      end
      old_w = m_mem[10];
      new_w = ~old_w;
      valid = 1; din = new_w; idx = 10; rd_en = 1; rd_addr = 10;
      tick();
      n_checks++;
      if (data_out !== old_w || rd_valid !== 1'b1) begin n_fail++; $display("FAIL rw_read_first: got %h/%b exp %h/1", data_out, rd_valid, old_w); end
      rd_en = 1; rd_addr = 10; tick();
      n_checks++;
      if (data_out !== new_w) begin n_fail++; $display("FAIL rw_new_value: got %h exp %h", data_out, new_w); end
   endtask
   task automatic test_reset_mid();
      logic [DW-1:0] d0, d1;
      rst = 0; valid = 1; idx = 0; din = '1; rd_en = 1; rd_addr = 3;
      tick();
      rst = 1;
      n_checks++;
      if ({asrt, asrt_msb, asrt_idx, ovf, busy, rd_valid} !== '0 || data_out !== '0)
         begin n_fail++; $display("FAIL mid_reset: got %b/%h exp 0/0", {asrt, asrt_msb, asrt_idx, ovf, busy, rd_valid}, data_out); end
      for (int k = 0; k < 5; k++) begin
         valid = 1; idx = 0; din = {$urandom, $urandom};
         tick();
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ignore: busy %b exp 0", busy); end
      d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      arm = 1; tick();
      valid = 1; idx = 0; din = d0; tick();
      valid = 1; idx = 1; din = d1; tick();
      stop = 1; tick();
      rd_en = 1; rd_addr = 0; tick();
      n_checks++;
      if (data_out !== d0) begin n_fail++; $display("FAIL restart_addr0: got %h exp %h", data_out, d0); end
      rd_en = 1; rd_addr = 1; tick();
      n_checks++;
      if (data_out !== d1) begin n_fail++; $display("FAIL restart_addr1: got %h exp %h", data_out, d1); end
   endtask
   task automatic test_random();
      logic [IW-1:0] seq;
      seq = '0;
      for (int i = 0; i < 3000; i++) begin
         arm   = ($urandom_range(0, m_state == 0 ? 20 : 600) == 0);
         stop  = ($urandom_range(0, 600) == 0);
         valid = ($urandom_range(0, 3) != 0);
         idx   = ($urandom_range(0, 50) == 0) ? IW'($urandom) : seq;
         din   = {$urandom, $urandom};
         ack   = ($urandom_range(0, 5) == 0);
         rd_en = ($urandom_range(0, 1) == 1);
         rd_addr = AW'($urandom);
         if (valid) seq = idx + 1'b1;
         tick();
         n_checks++;
         if ({asrt, asrt_msb, asrt_idx, ovf, busy, rd_valid} !== {m_assert, m_msb, m_idx, m_ovf, m_state != 0, m_rdv} || data_out !== m_dout)
            begin n_fail++; $display("FAIL random cycle %0d: got %b/%h exp %b/%h", i, {asrt, asrt_msb, asrt_idx, ovf, busy, rd_valid}, data_out, {m_assert, m_msb, m_idx, m_ovf, m_state != 0, m_rdv}, m_dout); end
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_fill();
      test_align();
      test_overflow();
      test_ack_collide();
      test_rw_collide();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
